// File: rtl/tile_row_fetcher_if.sv
// Handshake and Ram-read bundle between the tile row fetcher and its
// neighbours. master = fetcher side, slave = requester/Ram/renderer side.
interface tile_row_fetcher_if #(
  parameter int Bits         = 16,
  parameter int MapWidthLog2 = 6
);
  logic                    reqValid;
  logic                    reqReady;
  logic [MapWidthLog2-1:0] tileX;
  logic [4:0]              tileY;
  logic [2:0]              fineY;
  logic [Bits-1:0]         ramAddress;
  logic [7:0]              ramData;
  logic                    pixelValid;
  logic                    pixelReady;
  logic [5:0]              pixelColor;
  logic                    pixelLast;

  modport master (
    output reqReady, ramAddress, pixelValid, pixelColor, pixelLast,
    input  reqValid, tileX, tileY, fineY, ramData, pixelReady
  );
  modport slave (
    input  reqReady, ramAddress, pixelValid, pixelColor, pixelLast,
    output reqValid, tileX, tileY, fineY, ramData, pixelReady
  );
endinterface

// File: rtl/tile_row_fetcher.sv
// Reads one name-table entry plus one 4bpp pattern row from shared Ram and
// streams 8 attributed pixels (flip-h/flip-v/palette) over valid/ready.
module tile_row_fetcher #(
  parameter int              Bits         = 16,
  parameter logic [Bits-1:0] NameBase     = 16'h0000,
  parameter logic [Bits-1:0] PatternBase  = 16'h2000,
  parameter int              MapWidthLog2 = 6
) (
  input logic              clk,
  input logic              reset,
  tile_row_fetcher_if.master bus
);
  typedef enum logic [2:0] {IDLE, NAME_LO, NAME_HI, PAT0, PAT1, PAT2, PAT3, OUT} state_t;

  state_t          state;
  logic [7:0]      tile_idx;
  logic [2:0]      fine;
  logic            flip_h;
  logic [1:0]      pal;
  logic [31:0]     pix;
  logic [2:0]      cnt;
  logic [Bits-1:0] addr;
  logic            pvalid, plast;
  logic [5:0]      pcolor;

  logic [Bits-1:0] name_addr, pat_addr;
  logic [2:0]      pat_row;
  logic [7:0]      din;

  assign name_addr = NameBase + (Bits'(bus.tileY) << (MapWidthLog2 + 1)) + (Bits'(bus.tileX) << 1);
  // In NAME_HI ramData is the attribute byte, so the pattern row is resolved from it directly.
  assign pat_row   = bus.ramData[6] ? ~fine : fine;
  assign pat_addr  = PatternBase + (Bits'(tile_idx) << 5) + (Bits'(pat_row) << 2)
                   + (bus.ramData[7] ? Bits'(3) : Bits'(0));
  // Flip-h reads bytes right-to-left; swapping nibbles completes the mirror.
  assign din       = flip_h ? {bus.ramData[3:0], bus.ramData[7:4]} : bus.ramData;

  assign bus.reqReady   = (state == IDLE) && reset;
  assign bus.ramAddress = addr;
  assign bus.pixelValid = pvalid;
  assign bus.pixelColor = pcolor;
  assign bus.pixelLast  = plast;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tile_idx <= '0;
      fine     <= '0;
      flip_h   <= 1'b0;
      pal      <= '0;
      pix      <= '0;
      cnt      <= '0;
      addr     <= '0;
      pvalid   <= 1'b0;
      plast    <= 1'b0;
      pcolor   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.reqValid) begin
          fine  <= bus.fineY;
          addr  <= name_addr;
          state <= NAME_LO;
        end
        NAME_LO: begin
          tile_idx <= bus.ramData;
          addr     <= addr + Bits'(1);
          state    <= NAME_HI;
        end
        NAME_HI: begin
          flip_h <= bus.ramData[7];
          pal    <= bus.ramData[1:0];
          addr   <= pat_addr;
          state  <= PAT0;
        end
        PAT0, PAT1, PAT2: begin
          pix   <= {pix[23:0], din};
          addr  <= flip_h ? addr - Bits'(1) : addr + Bits'(1);
          state <= state_t'(state + 3'd1);
        end
        PAT3: begin
          pix    <= {pix[23:0], din};
          addr   <= '0;
          pvalid <= 1'b1;
          pcolor <= {pal, pix[23:20]};
          cnt    <= '0;
          plast  <= 1'b0;
          state  <= OUT;
        end
        OUT: if (bus.pixelReady) begin
          if (plast) begin
            pvalid <= 1'b0;
            plast  <= 1'b0;
            pcolor <= '0;
            state  <= IDLE;
          end else begin
            pix    <= pix << 4;
            pcolor <= {pal, pix[27:24]};
            cnt    <= cnt + 3'd1;
            plast  <= (cnt == 3'd6);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
